xadc_scan_controller: RTL

//  Parametrised, N-channel successor to the fixed two-channel ADC controller.
//  - Each XADC end-of-conversion starts one scan: the block reads NUM_CH DRP

---
 rtl/xadc_scan_controller.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/xadc_scan_controller.sv
// xadc_scan_controller
//   N-channel XADC scan sequencer. Each end-of-conversion pulse starts one scan
//   that issues one DRP read per entry of ADDR_LIST, in order, and stores the
//   DATA_W-bit result of each read. A read that sees no drdy within TIMEOUT_CYC
//   cycles is abandoned, flagged, and leaves its channel untouched.
//
//   Optional feature macro: XADC_SCAN_AVG_EN
//     When defined, each channel averages four good samples before its result
//     register and valid bit are updated.
//
// Ports
//   i_clk          system / DRP clock
//   i_rst_n        synchronous reset, active low
//   i_eoc          XADC end-of-conversion pulse, starts a scan when idle
//   i_drdy         DRP data ready
//   i_do_in        DRP read data, result taken from the top DATA_W bits
//   o_den          DRP enable, one-cycle pulse per read
//   o_daddr        DRP address, holds its last value between reads
//   o_dwe          DRP write enable, always 0
//   o_ch_data      packed per-channel results, ch0 in the LSBs
//   o_ch_valid     per-channel "has a result" bits
//   o_scan_done    one-cycle pulse in the final store cycle of a scan
//   o_busy         high from the cycle after eoc acceptance through the final store
//   o_overrun      sticky: eoc seen while a scan was in progress
//   o_timeout_err  sticky: a read was abandoned for lack of drdy
module xadc_scan_controller #(
  parameter int unsigned         NUM_CH      = 2,
  parameter logic [NUM_CH*8-1:0] ADDR_LIST   = {8'h1B, 8'h13},
  parameter int unsigned         DATA_W      = 12,
  parameter int unsigned         TIMEOUT_CYC = 255
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_eoc,
  input  logic                     i_drdy,
  input  logic [15:0]              i_do_in,
  output logic                     o_den,
  output logic [6:0]               o_daddr,
  output logic                     o_dwe,
  output logic [NUM_CH*DATA_W-1:0] o_ch_data,
  output logic [NUM_CH-1:0]        o_ch_valid,
  output logic                     o_scan_done,
  output logic                     o_busy,
  output logic                     o_overrun,
  output logic                     o_timeout_err
);

  localparam int unsigned IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StStore} state_e;

  state_e              r_state;
  state_e              w_state_next;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic [TCNT_W-1:0]   r_tcnt;
  logic [DATA_W-1:0]   r_sample;
  logic                r_hit;      // current read got drdy (not abandoned)
  logic [6:0]          r_daddr;
  logic                r_busy;
  logic                r_overrun;
  logic                r_timeout;
  logic                w_last;
  logic                w_tmo;

  assign w_last    = (r_idx == IDX_W'(NUM_CH - 1));
  assign w_idx_nxt = r_idx + IDX_W'(1);
  // Last WAIT cycle in which drdy is still accepted.
  assign w_tmo     = (r_tcnt == TCNT_W'(TIMEOUT_CYC - 1));

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (i_eoc) w_state_next = StReq;
      StReq:   w_state_next = StWait;
      StWait:  if (i_drdy || w_tmo) w_state_next = StStore;
      StStore: w_state_next = w_last ? StIdle : StReq;
      default: w_state_next = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    o_den         = (r_state == StReq);
    o_scan_done   = (r_state == StStore) && w_last;
    o_daddr       = r_daddr;
    o_dwe         = 1'b0;
    o_busy        = r_busy;
    o_overrun     = r_overrun;
    o_timeout_err = r_timeout;
  end

  // Sequencing datapath
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_idx     <= '0;
      r_tcnt    <= '0;
      r_sample  <= '0;
      r_hit     <= 1'b0;
      r_daddr   <= '0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (i_eoc && (r_state != StIdle)) r_overrun <= 1'b1;
      unique case (r_state)
        StIdle: begin
          if (i_eoc) begin
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_daddr <= ADDR_LIST[6:0];
          end
        end
        StReq: begin
          r_tcnt <= '0;
          r_hit  <= 1'b0;
        end
        StWait: begin
          if (i_drdy) begin
            r_sample <= i_do_in[15 -: DATA_W];
            r_hit    <= 1'b1;
          end else begin
            r_tcnt <= r_tcnt + TCNT_W'(1);
            if (w_tmo) r_timeout <= 1'b1;
          end
        end
        StStore: begin
          if (w_last) begin
            r_busy <= 1'b0;
          end else begin
            r_idx   <= w_idx_nxt;
            r_daddr <= ADDR_LIST[int'(w_idx_nxt)*8 +: 7];
          end
        end
        default: ;
      endcase
    end
  end

  // Per-channel result storage
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic              w_store;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;

    assign w_store = (r_state == StStore) && r_hit && (r_idx == IDX_W'(k));

`ifdef XADC_SCAN_AVG_EN
    logic [DATA_W+1:0] r_acc;
    logic [DATA_W+1:0] w_sum;
    logic [1:0]        r_cnt;

    assign w_sum = r_acc + {2'b00, r_sample};

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        r_acc   <= '0;
        r_cnt   <= '0;
        r_data  <= '0;
        r_valid <= 1'b0;
      end else if (w_store) begin
        if (r_cnt == 2'd3) begin
          r_data  <= w_sum[DATA_W+1:2];
          r_valid <= 1'b1;
          r_acc   <= '0;
          r_cnt   <= '0;
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + 2'd1;
        end
      end
    end
`else
    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        r_data  <= '0;
        r_valid <= 1'b0;
      end else if (w_store) begin
        r_data  <= r_sample;
        r_valid <= 1'b1;
      end
    end
`endif

    assign o_ch_data[k*DATA_W +: DATA_W] = r_data;
    assign o_ch_valid[k]                 = r_valid;
  end

  // Low DRP data bits below the result slice are intentionally dropped.
  if (DATA_W < 16) begin : g_lsb
    logic w_do_lsb_unused;
    assign w_do_lsb_unused = ^i_do_in[15-DATA_W:0];
  end

endmodule
